// File: rtl/object_pos_bank.sv
// ============================================================================
// object_pos_bank : double-buffered object position / score bank with an
// Avalon-MM slave port and a vertical-sync-aligned commit.
// Revision 1.0
// ============================================================================
`default_nettype none

module object_pos_bank #(
  parameter int NUM_OBJ = 9,
  parameter int COORD_W = 10,
  parameter int SCORE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4:0]                 avs_address,
  input  logic                       avs_chipselect,
  input  logic                       avs_read,
  input  logic                       avs_write,
  input  logic [31:0]                avs_writedata,
  output logic [31:0]                avs_readdata,
  input  logic                       vs_n,
  output logic [NUM_OBJ*COORD_W-1:0] obj_x,
  output logic [NUM_OBJ*COORD_W-1:0] obj_y,
  output logic [NUM_OBJ-1:0]         obj_vis,
  output logic [SCORE_W-1:0]         score_out,
  output logic                       frame_irq
);

  localparam logic [4:0] SCORE_ADDR = 5'(NUM_OBJ);
  localparam logic [4:0] CTRL_ADDR  = 5'(NUM_OBJ + 1);

  logic [COORD_W-1:0] sh_x_q  [NUM_OBJ];
  logic [COORD_W-1:0] sh_x_d  [NUM_OBJ];
  logic [COORD_W-1:0] sh_y_q  [NUM_OBJ];
  logic [COORD_W-1:0] sh_y_d  [NUM_OBJ];
  logic [COORD_W-1:0] act_x_q [NUM_OBJ];
  logic [COORD_W-1:0] act_x_d [NUM_OBJ];
  logic [COORD_W-1:0] act_y_q [NUM_OBJ];
  logic [COORD_W-1:0] act_y_d [NUM_OBJ];
  logic [NUM_OBJ-1:0] sh_vis_q, sh_vis_d;
  logic [NUM_OBJ-1:0] act_vis_q, act_vis_d;
  logic [SCORE_W-1:0] sh_score_q, sh_score_d;
  logic [SCORE_W-1:0] act_score_q, act_score_d;
  logic               commit_pending_q, commit_pending_d;
  logic               frame_irq_q, frame_irq_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               vs_q, vs_d;

  logic        wr_en;
  logic        rd_en;
  logic        frame_edge;
  logic        commit;
  logic [31:0] rd_word;

  logic unused_wd;
  assign unused_wd = ^avs_writedata;

  always_comb begin
    wr_en      = avs_chipselect && avs_write;
    rd_en      = avs_chipselect && avs_read;
    frame_edge = vs_q && !vs_n;
    commit     = frame_edge && commit_pending_q;

    sh_x_d           = sh_x_q;
    sh_y_d           = sh_y_q;
    sh_vis_d         = sh_vis_q;
    sh_score_d       = sh_score_q;
    act_x_d          = act_x_q;
    act_y_d          = act_y_q;
    act_vis_d        = act_vis_q;
    act_score_d      = act_score_q;
    commit_pending_d = commit_pending_q;
    frame_irq_d      = frame_irq_q;
    readdata_d       = readdata_q;
    vs_d             = vs_n;
    frame_cnt_d      = frame_cnt_q + {15'd0, frame_edge};
    rd_word          = '0;

    // The commit copies the registered shadow, so a same-cycle software
    // write lands in the shadow only and waits for the next commit.
    if (commit) begin
      act_x_d          = sh_x_q;
      act_y_d          = sh_y_q;
      act_vis_d        = sh_vis_q;
      act_score_d      = sh_score_q;
      commit_pending_d = 1'b0;
    end

    if (wr_en) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (avs_address == 5'(i)) begin
          sh_x_d[i]   = avs_writedata[COORD_W-1:0];
          sh_y_d[i]   = avs_writedata[16 +: COORD_W];
          sh_vis_d[i] = avs_writedata[31];
        end
      end
      if (avs_address == SCORE_ADDR) begin
        sh_score_d = avs_writedata[SCORE_W-1:0];
      end
      if (avs_address == CTRL_ADDR) begin
        if (avs_writedata[0]) begin
          commit_pending_d = 1'b1;
        end
        if (avs_writedata[1]) begin
          frame_irq_d = 1'b0;
        end
      end
    end

    // Applied after the clear so a coincident commit keeps the flag set.
    if (commit) begin
      frame_irq_d = 1'b1;
    end

    for (int i = 0; i < NUM_OBJ; i++) begin
      if (avs_address == 5'(i)) begin
        rd_word[COORD_W-1:0]   = sh_x_q[i];
        rd_word[16 +: COORD_W] = sh_y_q[i];
        rd_word[31]            = sh_vis_q[i];
      end
    end
    if (avs_address == SCORE_ADDR) begin
      rd_word[SCORE_W-1:0] = sh_score_q;
    end
    if (avs_address == CTRL_ADDR) begin
      rd_word = {frame_cnt_q, 14'd0, frame_irq_q, commit_pending_q};
    end

    if (rd_en) begin
      readdata_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_x_q[i]  <= '0;
        sh_y_q[i]  <= '0;
        act_x_q[i] <= '0;
        act_y_q[i] <= '0;
      end
      sh_vis_q         <= '0;
      act_vis_q        <= '0;
      sh_score_q       <= '0;
      act_score_q      <= '0;
      commit_pending_q <= 1'b0;
      frame_irq_q      <= 1'b0;
      frame_cnt_q      <= '0;
      readdata_q       <= '0;
      vs_q             <= 1'b1;
    end else begin
      sh_x_q           <= sh_x_d;
      sh_y_q           <= sh_y_d;
      act_x_q          <= act_x_d;
      act_y_q          <= act_y_d;
      sh_vis_q         <= sh_vis_d;
      act_vis_q        <= act_vis_d;
      sh_score_q       <= sh_score_d;
      act_score_q      <= act_score_d;
      commit_pending_q <= commit_pending_d;
      frame_irq_q      <= frame_irq_d;
      frame_cnt_q      <= frame_cnt_d;
      readdata_q       <= readdata_d;
      vs_q             <= vs_d;
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_pack
    assign obj_x[g*COORD_W +: COORD_W] = act_x_q[g];
    assign obj_y[g*COORD_W +: COORD_W] = act_y_q[g];
  end

  assign obj_vis      = act_vis_q;
  assign score_out    = act_score_q;
  assign frame_irq    = frame_irq_q;
  assign avs_readdata = readdata_q;

endmodule

`default_nettype wire

// File: tb/tb_object_pos_bank.sv
// ============================================================================
// tb_object_pos_bank : randomized and directed bench for object_pos_bank
// against a behavioural model of the shadow/active banks.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_object_pos_bank;

  localparam int NUM_OBJ = 9;
  localparam int COORD_W = 10;
  localparam int SCORE_W = 16;
  localparam logic [4:0] SCORE_A = 5'(NUM_OBJ);
  localparam logic [4:0] CTRL_A  = 5'(NUM_OBJ + 1);

  logic                       clk;
  logic                       reset;
  logic [4:0]                 avs_address;
  logic                       avs_chipselect;
  logic                       avs_read;
  logic                       avs_write;
  logic [31:0]                avs_writedata;
  logic [31:0]                avs_readdata;
  logic                       vs_n;
  logic [NUM_OBJ*COORD_W-1:0] obj_x;
  logic [NUM_OBJ*COORD_W-1:0] obj_y;
  logic [NUM_OBJ-1:0]         obj_vis;
  logic [SCORE_W-1:0]         score_out;
  logic                       frame_irq;

  object_pos_bank #(.NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address),
    .avs_chipselect(avs_chipselect), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .vs_n(vs_n),
    .obj_x(obj_x), .obj_y(obj_y), .obj_vis(obj_vis), .score_out(score_out),
    .frame_irq(frame_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int unsigned m_sh_x [NUM_OBJ];
  int unsigned m_sh_y [NUM_OBJ];
  int unsigned m_sh_v [NUM_OBJ];
  int unsigned m_ac_x [NUM_OBJ];
  int unsigned m_ac_y [NUM_OBJ];
  int unsigned m_ac_v [NUM_OBJ];
  int unsigned m_sh_score, m_ac_score;
  bit          m_pending, m_irq, m_vs;
  int unsigned m_cnt;
  logic [31:0] m_rd;

  function automatic void model_reset();
    for (int i = 0; i < NUM_OBJ; i++) begin
      m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_v[i] = 0;
      m_ac_x[i] = 0; m_ac_y[i] = 0; m_ac_v[i] = 0;
    end
    m_sh_score = 0; m_ac_score = 0;
    m_pending = 0; m_irq = 0; m_vs = 1; m_cnt = 0; m_rd = 0;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    int unsigned w;
    if (a < NUM_OBJ)       w = m_sh_v[a] * 32'h8000_0000 + m_sh_y[a] * 65536 + m_sh_x[a];
    else if (a == NUM_OBJ) w = m_sh_score;
    else if (a == NUM_OBJ + 1) w = m_cnt * 65536 + (m_irq ? 2 : 0) + (m_pending ? 1 : 0);
    else w = 0;
    return 32'(w);
  endfunction

  function automatic logic [NUM_OBJ*COORD_W-1:0] exp_x();
    logic [NUM_OBJ*COORD_W-1:0] r = '0;
    for (int i = 0; i < NUM_OBJ; i++) r[i*COORD_W +: COORD_W] = COORD_W'(m_ac_x[i]);
    return r;
  endfunction

  function automatic logic [NUM_OBJ*COORD_W-1:0] exp_y();
    logic [NUM_OBJ*COORD_W-1:0] r = '0;
    for (int i = 0; i < NUM_OBJ; i++) r[i*COORD_W +: COORD_W] = COORD_W'(m_ac_y[i]);
    return r;
  endfunction

  function automatic logic [NUM_OBJ-1:0] exp_vis();
    logic [NUM_OBJ-1:0] r = '0;
    for (int i = 0; i < NUM_OBJ; i++) r[i] = (m_ac_v[i] != 0);
    return r;
  endfunction

  // One clock cycle of stimulus; the model advances by the same cycle.
  task automatic cyc(input bit cs, input bit rd, input bit wr, input int a,
                     input logic [31:0] wd, input bit vsn);
    bit edge_seen, commit;
    @(negedge clk);
    avs_chipselect = cs; avs_read = rd; avs_write = wr;
    avs_address = 5'(a); avs_writedata = wd; vs_n = vsn;
    if (cs && rd) m_rd = model_read(a);
    edge_seen = m_vs && !vsn;
    m_vs = vsn;
    commit = edge_seen && m_pending;
    if (edge_seen) m_cnt = (m_cnt + 1) % 65536;
    if (commit) begin
      m_ac_x = m_sh_x; m_ac_y = m_sh_y; m_ac_v = m_sh_v; m_ac_score = m_sh_score;
      m_pending = 0; m_irq = 1;
    end
    if (cs && wr) begin
      if (a < NUM_OBJ) begin
        m_sh_x[a] = wd % (1 << COORD_W);
        m_sh_y[a] = (wd / 65536) % (1 << COORD_W);
        m_sh_v[a] = wd / 32'h8000_0000;
      end else if (a == NUM_OBJ) begin
        m_sh_score = wd % (64'd1 << SCORE_W);
      end else if (a == NUM_OBJ + 1) begin
        if (wd % 2 == 1) m_pending = 1;
        if ((wd / 2) % 2 == 1 && !commit) m_irq = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();                           cyc(0, 0, 0, 0, 32'd0, 1); endtask
  task automatic wr(input int a, input logic [31:0] d); cyc(1, 0, 1, a, d, 1);   endtask
  task automatic rdr(input int a);                 cyc(1, 1, 0, a, 32'd0, 1); endtask
  task automatic pulse();                          cyc(0, 0, 0, 0, 32'd0, 0); idle(); endtask

  // Reset with an Avalon write and a low vs_n presented, both to be ignored.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1; avs_chipselect = 1; avs_write = 1; avs_read = 1;
    avs_address = 5'd0; avs_writedata = $urandom; vs_n = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 0; avs_chipselect = 0; avs_write = 0; avs_read = 0; vs_n = 1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if (obj_x !== '0) begin failures++; $display("FAIL reset_obj_x got=%h exp=0", obj_x); end
    checks++; if (obj_y !== '0) begin failures++; $display("FAIL reset_obj_y got=%h exp=0", obj_y); end
    checks++; if (obj_vis !== '0) begin failures++; $display("FAIL reset_obj_vis got=%h exp=0", obj_vis); end
    checks++; if (score_out !== '0) begin failures++; $display("FAIL reset_score got=%h exp=0", score_out); end
    checks++; if (frame_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", frame_irq); end
    checks++; if (avs_readdata !== 32'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", avs_readdata); end
    rdr(2);
    checks++; if (avs_readdata !== 32'd0) begin failures++; $display("FAIL reset_read_addr2 got=%h exp=0", avs_readdata); end
    rdr(CTRL_A);
    checks++; if (avs_readdata !== 32'd0) begin failures++; $display("FAIL reset_read_ctrl got=%h exp=0", avs_readdata); end
  endtask

  task automatic test_no_commit();
    wr(1, 32'h8064_0140);
    repeat (3) pulse();
    checks++; if (obj_x[COORD_W +: COORD_W] !== '0) begin failures++; $display("FAIL nocommit_slot1_x got=%h exp=0", obj_x[COORD_W +: COORD_W]); end
    checks++; if (obj_vis !== exp_vis()) begin failures++; $display("FAIL nocommit_vis got=%h exp=%h", obj_vis, exp_vis()); end
    rdr(CTRL_A);
    checks++; if (avs_readdata !== 32'h0003_0000) begin failures++; $display("FAIL nocommit_ctrl got=%h exp=00030000", avs_readdata); end
    rdr(1);
    checks++; if (avs_readdata !== 32'h8064_0140) begin failures++; $display("FAIL shadow_read_slot1 got=%h exp=80640140", avs_readdata); end
  endtask

  task automatic test_commit();
    wr(CTRL_A, 32'h1);
    checks++; if (obj_x !== '0) begin failures++; $display("FAIL commit_early got=%h exp=0", obj_x); end
    cyc(0, 0, 0, 0, 32'd0, 0);
    checks++; if (obj_x[COORD_W +: COORD_W] !== 10'h140) begin failures++; $display("FAIL commit_x got=%h exp=140", obj_x[COORD_W +: COORD_W]); end
    checks++; if (obj_y[COORD_W +: COORD_W] !== 10'h064) begin failures++; $display("FAIL commit_y got=%h exp=064", obj_y[COORD_W +: COORD_W]); end
    checks++; if (obj_vis !== 9'h002) begin failures++; $display("FAIL commit_vis got=%h exp=002", obj_vis); end
    checks++; if (frame_irq !== 1'b1) begin failures++; $display("FAIL commit_irq got=%b exp=1", frame_irq); end
    idle();
    rdr(CTRL_A);
    checks++; if (avs_readdata !== 32'h0004_0002) begin failures++; $display("FAIL commit_ctrl got=%h exp=00040002", avs_readdata); end
  endtask

  task automatic test_write_during_commit();
    wr(CTRL_A, 32'h1);
    cyc(1, 0, 1, 0, 32'h0000_0005, 0);
    checks++; if (obj_x[COORD_W-1:0] !== '0) begin failures++; $display("FAIL wdc_old_x got=%h exp=0", obj_x[COORD_W-1:0]); end
    idle();
    wr(CTRL_A, 32'h1);
    pulse();
    checks++; if (obj_x[COORD_W-1:0] !== 10'd5) begin failures++; $display("FAIL wdc_new_x got=%h exp=5", obj_x[COORD_W-1:0]); end
    checks++; if (obj_x !== exp_x()) begin failures++; $display("FAIL wdc_all_x got=%h exp=%h", obj_x, exp_x()); end
  endtask

  task automatic test_irq_clear();
    wr(CTRL_A, 32'h1);
    cyc(1, 0, 1, CTRL_A, 32'h2, 0);
    checks++; if (frame_irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins got=%b exp=1", frame_irq); end
    idle();
    wr(CTRL_A, 32'h2);
    checks++; if (frame_irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", frame_irq); end
    wr(CTRL_A, 32'h0);
    rdr(CTRL_A);
    checks++; if (avs_readdata !== m_rd) begin failures++; $display("FAIL ctrl_noop got=%h exp=%h", avs_readdata, m_rd); end
  endtask

  task automatic test_commit_same_edge();
    wr(2, 32'h8123_0077);
    wr(SCORE_A, 32'hDEAD_BEEF);
    wr(CTRL_A, 32'h1);
    cyc(1, 0, 1, CTRL_A, 32'h1, 0);
    checks++; if (obj_x[2*COORD_W +: COORD_W] !== 10'h077) begin failures++; $display("FAIL same_edge_x got=%h exp=077", obj_x[2*COORD_W +: COORD_W]); end
    checks++; if (score_out !== 16'hBEEF) begin failures++; $display("FAIL same_edge_score got=%h exp=beef", score_out); end
    idle();
    rdr(CTRL_A);
    checks++; if (avs_readdata[0] !== 1'b1) begin failures++; $display("FAIL same_edge_pending got=%b exp=1", avs_readdata[0]); end
    checks++; if (avs_readdata !== m_rd) begin failures++; $display("FAIL same_edge_ctrl got=%h exp=%h", avs_readdata, m_rd); end
  endtask

  task automatic test_unmapped();
    for (int a = NUM_OBJ + 2; a < 32; a++) wr(a, $urandom);
    wr(31, 32'hFFFF_FFFF);
    checks++; if (obj_x !== exp_x()) begin failures++; $display("FAIL unmapped_x got=%h exp=%h", obj_x, exp_x()); end
    for (int a = 0; a < NUM_OBJ + 2; a++) begin
      rdr(a);
      checks++; if (avs_readdata !== m_rd) begin failures++; $display("FAIL unmapped_shadow a=%0d got=%h exp=%h", a, avs_readdata, m_rd); end
    end
    rdr(31);
    checks++; if (avs_readdata !== 32'd0) begin failures++; $display("FAIL read_addr31 got=%h exp=0", avs_readdata); end
  endtask

  task automatic test_random();
    int a;
    for (int n = 0; n < 600; n++) begin
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, NUM_OBJ + 1));
      cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom), bit'($urandom), a,
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom),
          bit'($urandom_range(0, 3) != 0));
      checks++; if (obj_x !== exp_x()) begin failures++; $display("FAIL rand_x n=%0d got=%h exp=%h", n, obj_x, exp_x()); end
      checks++; if (obj_y !== exp_y()) begin failures++; $display("FAIL rand_y n=%0d got=%h exp=%h", n, obj_y, exp_y()); end
      checks++; if (obj_vis !== exp_vis()) begin failures++; $display("FAIL rand_vis n=%0d got=%h exp=%h", n, obj_vis, exp_vis()); end
      checks++; if (score_out !== SCORE_W'(m_ac_score)) begin failures++; $display("FAIL rand_score n=%0d got=%h exp=%h", n, score_out, SCORE_W'(m_ac_score)); end
      checks++; if (frame_irq !== m_irq) begin failures++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, frame_irq, m_irq); end
      checks++; if (avs_readdata !== m_rd) begin failures++; $display("FAIL rand_readdata n=%0d got=%h exp=%h", n, avs_readdata, m_rd); end
    end
    idle();
  endtask

  // Preloads the frame counter near its top to reach the wrap quickly.
  task automatic test_wrap();
    idle();
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFD;
    @(posedge clk);
    #1;
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFD;
    pulse(); pulse();
    rdr(CTRL_A);
    checks++; if (avs_readdata[31:16] !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff", avs_readdata[31:16]); end
    pulse();
    rdr(CTRL_A);
    checks++; if (avs_readdata[31:16] !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", avs_readdata[31:16]); end
    checks++; if (avs_readdata !== m_rd) begin failures++; $display("FAIL wrap_ctrl got=%h exp=%h", avs_readdata, m_rd); end
  endtask

  task automatic test_reset_mid();
    wr(4, 32'h83FF_03FF);
    wr(CTRL_A, 32'h1);
    do_reset(2);
    checks++; if (obj_x !== '0 || obj_y !== '0 || obj_vis !== '0) begin failures++; $display("FAIL midreset_obj got=%h/%h/%h exp=0", obj_x, obj_y, obj_vis); end
    checks++; if (frame_irq !== 1'b0 || score_out !== '0) begin failures++; $display("FAIL midreset_irq_score got=%b/%h exp=0/0", frame_irq, score_out); end
    pulse();
    checks++; if (obj_x !== '0) begin failures++; $display("FAIL midreset_no_commit got=%h exp=0", obj_x); end
    rdr(CTRL_A);
    checks++; if (avs_readdata !== 32'h0001_0000) begin failures++; $display("FAIL midreset_ctrl got=%h exp=00010000", avs_readdata); end
    rdr(4);
    checks++; if (avs_readdata !== 32'd0) begin failures++; $display("FAIL midreset_shadow got=%h exp=0", avs_readdata); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; avs_address = '0; avs_chipselect = 0; avs_read = 0;
    avs_write = 0; avs_writedata = '0; vs_n = 1;
    model_reset();
    test_reset();
    test_no_commit();
    test_commit();
    test_write_during_commit();
    test_irq_clear();
    test_commit_same_edge();
    test_unmapped();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
